// File: rtl/down_timer_if.sv
// ----------------------------------------------------------------------------
// down_timer_if
//
// Control and status bundle for the down_timer block. The bus master
// (CPU-side logic or a testbench) drives the load/control inputs and
// observes the status flags. The tri-stated count read-back stays a plain
// port on the timer so the high-impedance drive lives on a module boundary.
//
// Parameters:
//   WIDTH          - width of load data
//   PRESCALE_WIDTH - width of the prescale value
//
// Signals:
//   ld        master->slave  load count and reload registers from in
//   in        master->slave  load data
//   oe        master->slave  output enable for the count read-back
//   start     master->slave  begin/resume counting
//   stop      master->slave  pause counting
//   auto      master->slave  auto-reload mode, sampled at expiry
//   prescale  master->slave  clock edges per decrement minus 1
//   running   slave->master  high while the timer is counting
//   expired   slave->master  one-cycle pulse on expiry
//   done      slave->master  sticky one-shot expiry flag
// ----------------------------------------------------------------------------
interface down_timer_if #(
    parameter int WIDTH          = 32,
    parameter int PRESCALE_WIDTH = 8
) ();

    logic                      ld;
    logic [WIDTH-1:0]          in;
    logic                      oe;
    logic                      start;
    logic                      stop;
    logic                      auto;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      running;
    logic                      expired;
    logic                      done;

    modport master (
        output ld, in, oe, start, stop, auto, prescale,
        input  running, expired, done
    );

    modport slave (
        input  ld, in, oe, start, stop, auto, prescale,
        output running, expired, done
    );

endinterface

// File: rtl/down_timer.sv
// ----------------------------------------------------------------------------
// down_timer
//
// Programmable down-counting timer with a reload register, a prescaler and
// expiry signalling. A loaded interval is counted down to zero; on expiry the
// timer either reloads and keeps running (auto mode) or parks in DONE with a
// sticky done flag (one-shot mode). The expired pulse feeds interrupt logic.
//
// Parameters:
//   WIDTH          - width of count, reload and bus data
//   PRESCALE_WIDTH - width of prescale input and internal prescale counter
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - down_timer_if.slave control/status bundle
//   out  - current count when bus.oe=1, otherwise high-impedance
// ----------------------------------------------------------------------------
module down_timer #(
    parameter int WIDTH          = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    down_timer_if.slave      bus,
    output wire [WIDTH-1:0]  out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                    state, state_n;
    logic [WIDTH-1:0]          count, count_n;
    logic [WIDTH-1:0]          reload, reload_n;
    logic [PRESCALE_WIDTH-1:0] pre, pre_n;
    logic                      expired_q, expired_n;
    logic                      done_q, done_n;

    // State register together with the datapath registers it controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            reload    <= '0;
            pre       <= '0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            reload    <= reload_n;
            pre       <= pre_n;
            expired_q <= expired_n;
            done_q    <= done_n;
        end
    end

    // Next-state logic. Priority is ld > stop > start > tick; stop also
    // suppresses a simultaneous start even when it has nothing to pause.
    // The prescaler uses >= so lowering prescale mid-run can never leave
    // pre stranded above the new limit.
    always_comb begin
        state_n   = state;
        count_n   = count;
        reload_n  = reload;
        pre_n     = pre;
        done_n    = done_q;
        expired_n = 1'b0;

        if (bus.ld) begin
            count_n  = bus.in;
            reload_n = bus.in;
            pre_n    = '0;
            state_n  = IDLE;
            done_n   = 1'b0;
        end else if (bus.stop) begin
            if (state == RUN) begin
                state_n = IDLE;
            end
        end else if (bus.start && (state != RUN)) begin
            if ((state == IDLE) && (count != '0)) begin
                // Resume a paused interval; pre is kept so the period continues.
                state_n = RUN;
            end else if (reload != '0) begin
                count_n = reload;
                pre_n   = '0;
                done_n  = 1'b0;
                state_n = RUN;
            end
        end else if (state == RUN) begin
            if (pre >= bus.prescale) begin
                pre_n = '0;
                if (count > WIDTH'(1)) begin
                    count_n = count - WIDTH'(1);
                end else if (bus.auto) begin
                    count_n   = reload;
                    expired_n = 1'b1;
                end else begin
                    count_n   = '0;
                    expired_n = 1'b1;
                    done_n    = 1'b1;
                    state_n   = DONE;
                end
            end else begin
                pre_n = pre + PRESCALE_WIDTH'(1);
            end
        end
    end

    // Status outputs, all taken straight from registered state.
    always_comb begin
        bus.running = (state == RUN);
        bus.expired = expired_q;
        bus.done    = done_q;
    end

    // Read-back is combinational on oe so it floats even while in reset.
    assign out = bus.oe ? count : {WIDTH{1'bz}};

endmodule
